cache2reg_loader: RTL and testbench

- Return path for data-memory loads: the cache-to-register counterpart of the store-data path.
- Takes a load request from the MEM stage and issues a word-aligned read to the data cache, then waits for the acknowledge.
- Extracts the byte, halfword or word, sign- or zero-extends it, and presents it to register writeback with a one-cycle valid pulse.
- Flags misaligned accesses and cache timeouts. Drives a busy signal so the pipeline stalls.

---
 rtl/cache2reg_loader.sv | 175 +++++++++++++++++
 tb/tb_cache2reg_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache2reg_loader.sv
// rtl/cache2reg_loader.sv - load return path: cache read, lane extract, extend, writeback pulse
module cache2reg_loader #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_req_i,
    input  logic [31:0] load_addr_i,
    input  logic [1:0]  load_size_i,
    input  logic        load_signed_i,
    input  logic [4:0]  load_rd_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        busy_o,
    output logic        load_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A zero TIMEOUT means wait forever for the acknowledge.
    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        load_err_q, load_err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [4:0]  rd_q, rd_d;

    logic        req_legal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Legality of the incoming request: reserved size or misaligned address is rejected.
    always_comb begin
        req_legal = 1'b0;
        case (load_size_i)
            2'b00:   req_legal = 1'b1;
            2'b01:   req_legal = ~load_addr_i[0];
            2'b10:   req_legal = (load_addr_i[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension of the returned word, using the latched request.
    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: ext_data = mem_rdata_i;
        endcase
    end

    // Next-state and output logic; pulses default low, everything else holds.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        load_err_d = 1'b0;
        cnt_d      = cnt_q;
        off_d      = off_q;
        size_d     = size_q;
        signed_d   = signed_q;
        rd_d       = rd_q;
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
                    if (req_legal) begin
                        off_d      = load_addr_i[1:0];
                        size_d     = load_size_i;
                        signed_d   = load_signed_i;
                        rd_d       = load_rd_i;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {load_addr_i[31:2], 2'b00};
                        cnt_d      = 8'd0;
                        state_d    = S_WAIT;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Acknowledge takes priority over an expiring timeout in the same cycle.
                if (mem_ack_i) begin
                    mem_req_d  = 1'b0;
                    wb_data_d  = ext_data;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    mem_req_d  = 1'b0;
                    load_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops an in-flight request immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            load_err_q <= 1'b0;
            cnt_q      <= 8'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            rd_q       <= 5'd0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            load_err_q <= load_err_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            rd_q       <= rd_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign load_err_o = load_err_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache2reg_loader.sv
// tb/tb_cache2reg_loader.sv - scoreboard bench for cache2reg_loader
module tb_cache2reg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [1:0]  load_size = 2'd0;
    logic        load_signed = 1'b0;
    logic [4:0]  load_rd = 5'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        load_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    cache2reg_loader #(.TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .load_req_i    (load_req),
        .load_addr_i   (load_addr),
        .load_size_i   (load_size),
        .load_signed_i (load_signed),
        .load_rd_i     (load_rd),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .busy_o        (busy),
        .load_err_o    (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drive a one-cycle request starting at a negedge; returns at the next negedge.
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic sg, input logic [4:0] rd);
        load_req    = 1'b1;
        load_addr   = a;
        load_size   = s;
        load_signed = sg;
        load_rd     = rd;
        @(negedge clk);
        load_req    = 1'b0;
        load_addr   = $urandom;
        load_signed = 1'($urandom);
    endtask

    // Hold ack low for 'waits' cycles, ack once, then look for wb_valid (bounded).
    task automatic complete(input int waits, input logic [31:0] rdata, output logic seen,
                            output int lat, output logic [4:0] rd, output logic [31:0] data,
                            output logic err);
        seen = 1'b0; lat = -1; rd = 5'd0; data = 32'd0; err = 1'b0;
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0;
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid) begin
                seen = 1'b1; lat = k; rd = wb_rd; data = wb_data; err = load_err;
                break;
            end
            @(negedge clk);
        end
        if (seen) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_vec++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_vec++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        n_vec++; if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin n_bad++; $display("FAIL reset_wb got=%h/%0d exp=0/0", wb_data, wb_rd); end
        n_vec++; if (load_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_err_busy got=%b/%b exp=0/0", load_err, busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        exp_t e;
        e.rd = 5'd5; e.data = 32'hDEAD_BEEF;
        issue(32'h0000_1004, 2'b10, 1'b0, 5'd5);
        sb_q.push_back(e);
        n_vec++; if (mem_req !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL word_wait got req=%b busy=%b exp=1/1", mem_req, busy); end
        n_vec++; if (mem_addr !== 32'h0000_1004) begin n_bad++; $display("FAIL word_addr got=%h exp=00001004", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        n_vec++; if (wb_valid !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin
            n_bad++; $display("FAIL word_done got valid=%b busy=%b req=%b exp=1/1/0", wb_valid, busy, mem_req); end
        e = sb_q.pop_front();
        n_vec++; if (wb_data !== e.data || wb_rd !== e.rd) begin
            n_bad++; $display("FAIL word_data got=%h/%0d exp=%h/%0d", wb_data, wb_rd, e.data, e.rd); end
        @(negedge clk);
        n_vec++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL word_idle got valid=%b busy=%b exp=0/0", wb_valid, busy); end
    endtask

    // Back-to-back loads: each new request lands in the IDLE cycle right after DONE.
    task automatic test_back_to_back();
        logic [31:0] a_t [9] = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2003,
                                 32'h2002, 32'h2000, 32'h2002, 32'h2000};
        logic [1:0]  s_t [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        logic        g_t [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] r_t [9] = '{32'h8081_7F01, 32'h8081_7F01, 32'h8081_7F01, 32'h8081_7F01,
                                 32'h8081_7F01, 32'hFFFE_1234, 32'hFFFE_1234, 32'hFFFE_1234,
                                 32'h0000_8001};
        logic [31:0] x_t [9] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FF81, 32'hFFFF_FF80,
                                 32'h0000_0080, 32'hFFFF_FFFE, 32'h0000_1234, 32'h0000_FFFE,
                                 32'hFFFF_8001};
        exp_t e;
        logic seen, err;
        int lat;
        logic [4:0] rd;
        logic [31:0] d;
        for (int i = 0; i < 9; i++) begin
            e.rd = 5'(i); e.data = x_t[i];
            issue(a_t[i], s_t[i], g_t[i], 5'(i));
            sb_q.push_back(e);
            complete(i % 2, r_t[i], seen, lat, rd, d, err);
            e = sb_q.pop_front();
            n_vec++;
            if (!seen) begin
                n_bad++; $display("FAIL b2b_%0d_valid got=none exp=wb_valid", i);
            end else if (d !== e.data || rd !== e.rd || lat !== 0) begin
                n_bad++; $display("FAIL b2b_%0d_data got=%h/%0d lat=%0d exp=%h/%0d lat=0", i, d, rd, lat, e.data, e.rd);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a_t [4] = '{32'h4001, 32'h4002, 32'h4000, 32'h4003};
        logic [1:0]  s_t [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            load_req = 1'b1; load_addr = a_t[i]; load_size = s_t[i]; load_rd = 5'd9;
            @(negedge clk);
            load_req = 1'b0;
            n_vec++; if (load_err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
                n_bad++; $display("FAIL misalign_%0d got err=%b req=%b busy=%b valid=%b exp=1/0/0/0", i, load_err, mem_req, busy, wb_valid); end
            @(negedge clk);
            n_vec++; if (load_err !== 1'b0 || mem_req !== 1'b0) begin
                n_bad++; $display("FAIL misalign_%0d_pulse got err=%b req=%b exp=0/0", i, load_err, mem_req); end
        end
    endtask

    task automatic test_timeout();
        int hi;
        exp_t e;
        logic seen, err;
        int lat;
        logic [4:0] rd;
        logic [31:0] d;
        issue(32'h5008, 2'b10, 1'b0, 5'd7);
        hi = 0;
        while (mem_req === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        n_vec++; if (hi !== 4) begin n_bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", hi); end
        n_vec++; if (load_err !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_err got err=%b valid=%b busy=%b exp=1/0/0", load_err, wb_valid, busy); end
        @(negedge clk);
        n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got=%b exp=0", load_err); end
        e.rd = 5'd8; e.data = 32'h1357_9BDF;
        issue(32'h500C, 2'b10, 1'b1, 5'd8);
        sb_q.push_back(e);
        complete(3, 32'h1357_9BDF, seen, lat, rd, d, err);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || err !== 1'b0 || d !== e.data || rd !== e.rd) begin
            n_bad++; $display("FAIL timeout_late_ack got seen=%b err=%b %h/%0d exp=1/0 %h/%0d", seen, err, d, rd, e.data, e.rd); end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        logic seen, err;
        int lat;
        logic [4:0] rd;
        logic [31:0] d;
        issue(32'h6000, 2'b10, 1'b0, 5'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midreset_drop got req=%b busy=%b exp=0/0", mem_req, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (wb_valid !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL midreset_stray_ack_%0d got valid=%b err=%b busy=%b exp=0/0/0", i, wb_valid, load_err, busy); end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        e.rd = 5'd0; e.data = 32'h0000_00AB;
        issue(32'h6001, 2'b00, 1'b0, 5'd0);
        sb_q.push_back(e);
        complete(1, 32'h0000_AB00, seen, lat, rd, d, err);
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || d !== e.data || rd !== e.rd) begin
            n_bad++; $display("FAIL midreset_next_load got seen=%b %h/%0d exp=1 %h/%0d", seen, d, rd, e.data, e.rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        n_vec++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
